mult32x32_fast_fsm: RTL and testbench

//   Sequencing controller for the fast 32x32 multiplier arithmetic unit.

---
 rtl/mult32x32_pkg.sv | 19 +
 rtl/mult32x32_fast_fsm.sv | 128 ++++++++++++
 tb/tb_mult32x32_fast_fsm.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mult32x32_pkg.sv
// Shared definitions for the fast 32x32 multiplier.
//   state_t   : sequencing states of the controller (IDLE plus one state per
//               16x16 partial product, named by which operand halves it uses)
//   SHIFT_*   : shift_sel encodings understood by the arithmetic unit
package mult32x32_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    A0B0 = 3'd1,
    A0B1 = 3'd2,
    A1B0 = 3'd3,
    A1B1 = 3'd4
  } state_t;

  localparam logic [1:0] SHIFT_0  = 2'b00;
  localparam logic [1:0] SHIFT_16 = 2'b01;
  localparam logic [1:0] SHIFT_32 = 2'b10;

endpackage

// File: rtl/mult32x32_fast_fsm.sv
// Sequencing controller for the fast 32x32 multiplier arithmetic unit.
// A start pulse in IDLE clears the product register and walks the 16x16
// partial-product schedule A0B0 -> A0B1 -> A1B0 -> A1B1, skipping products
// whose operand MSW is zero when SKIP_ZERO_MSW=1.
//
// Handshake: start is sampled only in IDLE (including the done cycle, which
// is an IDLE cycle, so back-to-back multiplies are possible); start while
// busy is ignored. done is a one-cycle pulse in the first IDLE cycle after
// the last step, and the product is valid in that cycle.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   start             : begin a multiply (IDLE only)
//   a_msw_is_0        : a[31:16]==0, from the arithmetic unit
//   b_msw_is_0        : b[31:16]==0, from the arithmetic unit
//   busy              : 1 in every non-IDLE state
//   done              : one-cycle completion pulse
//   a_sel, b_sel      : operand half select (0 low, 1 high)
//   shift_sel         : partial-product shift (00 <<0, 01 <<16, 10 <<32)
//   upd_prod          : accumulate partial product
//   clr_prod          : clear product register
//   dbg_state         : current state encoding, for observation only
module mult32x32_fast_fsm
  import mult32x32_pkg::*;
#(
  parameter logic SKIP_ZERO_MSW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       a_msw_is_0,
  input  logic       b_msw_is_0,
  output logic       busy,
  output logic       done,
  output logic       a_sel,
  output logic       b_sel,
  output logic [1:0] shift_sel,
  output logic       upd_prod,
  output logic       clr_prod,
  output logic [2:0] dbg_state
);

  state_t state;
  state_t state_nxt;
  logic   za;
  logic   zb;
  logic   done_q;

  // State, latched MSW-zero flags and the done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      za     <= 1'b0;
      zb     <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      // Leaving a step state for IDLE means the last product was accumulated.
      done_q <= (state != IDLE) && (state_nxt == IDLE);
      if ((state == IDLE) && start) begin
        za <= SKIP_ZERO_MSW & a_msw_is_0;
        zb <= SKIP_ZERO_MSW & b_msw_is_0;
      end
    end
  end

  // Next state and step decode. Outputs are forced low while reset is held
  // so that a mid-operation abort never leaks a step or clear to the unit.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    a_sel     = 1'b0;
    b_sel     = 1'b0;
    shift_sel = SHIFT_0;
    upd_prod  = 1'b0;
    clr_prod  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          clr_prod  = 1'b1;
          state_nxt = A0B0;
        end
      end
      A0B0: begin
        busy     = 1'b1;
        upd_prod = 1'b1;
        if (!zb)      state_nxt = A0B1;
        else if (!za) state_nxt = A1B0;
        else          state_nxt = IDLE;
      end
      A0B1: begin
        busy      = 1'b1;
        upd_prod  = 1'b1;
        b_sel     = 1'b1;
        shift_sel = SHIFT_16;
        state_nxt = (!za) ? A1B0 : IDLE;
      end
      A1B0: begin
        busy      = 1'b1;
        upd_prod  = 1'b1;
        a_sel     = 1'b1;
        shift_sel = SHIFT_16;
        state_nxt = (!zb) ? A1B1 : IDLE;
      end
      A1B1: begin
        busy      = 1'b1;
        upd_prod  = 1'b1;
        a_sel     = 1'b1;
        b_sel     = 1'b1;
        shift_sel = SHIFT_32;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (reset) begin
      busy      = 1'b0;
      a_sel     = 1'b0;
      b_sel     = 1'b0;
      shift_sel = SHIFT_0;
      upd_prod  = 1'b0;
      clr_prod  = 1'b0;
    end
  end

  assign done      = done_q & ~reset;
  assign dbg_state = state;

endmodule

// File: tb/tb_mult32x32_fast_fsm.sv
// Bench: two controllers (skipping and non-skipping) each driving a small
// behavioural arithmetic unit; every product is compared against a*b and
// every step's selects against the partial-product schedule derived from
// which operand MSWs are zero.
module tb_mult32x32_fast_fsm;

  logic        clk;
  logic        reset;
  logic        start_s, start_n;
  logic [31:0] a, b;
  logic        a_z, b_z;

  logic        busy_s, done_s, asel_s, bsel_s, upd_s, clr_s;
  logic [1:0]  shift_s;
  logic [2:0]  dbg_s;
  logic        busy_n, done_n, asel_n, bsel_n, upd_n, clr_n;
  logic [1:0]  shift_n;
  logic [2:0]  dbg_n;
  logic [63:0] prod_s, prod_n;

  int vectors;
  int miscompares;

  assign a_z = (a[31:16] == 16'h0);
  assign b_z = (b[31:16] == 16'h0);

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  mult32x32_fast_fsm #(.SKIP_ZERO_MSW(1'b1)) dut_s (
    .clk(clk), .reset(reset), .start(start_s),
    .a_msw_is_0(a_z), .b_msw_is_0(b_z),
    .busy(busy_s), .done(done_s), .a_sel(asel_s), .b_sel(bsel_s),
    .shift_sel(shift_s), .upd_prod(upd_s), .clr_prod(clr_s),
    .dbg_state(dbg_s)
  );

  mult32x32_fast_fsm #(.SKIP_ZERO_MSW(1'b0)) dut_n (
    .clk(clk), .reset(reset), .start(start_n),
    .a_msw_is_0(a_z), .b_msw_is_0(b_z),
    .busy(busy_n), .done(done_n), .a_sel(asel_n), .b_sel(bsel_n),
    .shift_sel(shift_n), .upd_prod(upd_n), .clr_prod(clr_n),
    .dbg_state(dbg_n)
  );

  // ---------------- behavioural arithmetic units ----------------
  function automatic logic [63:0] pp(input logic [31:0] x, input logic [31:0] y,
                                     input logic xs, input logic ys,
                                     input logic [1:0] sh);
    logic [15:0] xh, yh;
    logic [31:0] m;
    logic [63:0] w;
    xh = xs ? x[31:16] : x[15:0];
    yh = ys ? y[31:16] : y[15:0];
    m  = xh * yh;
    w  = {32'h0, m};
    return w << (16 * int'(sh));
  endfunction

  always @(posedge clk) begin
    if (reset)      prod_s <= 64'h0;
    else if (clr_s) prod_s <= 64'h0;
    else if (upd_s) prod_s <= prod_s + pp(a, b, asel_s, bsel_s, shift_s);
  end

  always @(posedge clk) begin
    if (reset)      prod_n <= 64'h0;
    else if (clr_n) prod_n <= 64'h0;
    else if (upd_n) prod_n <= prod_n + pp(a, b, asel_n, bsel_n, shift_n);
  end

  // ---------------- helpers ----------------
  typedef struct packed {
    logic        busy;
    logic        done;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic        upd;
    logic        clr;
    logic [63:0] prod;
  } obs_t;

  function automatic obs_t grab(input bit ns);
    obs_t o;
    if (ns) o = '{busy_n, done_n, asel_n, bsel_n, shift_n, upd_n, clr_n, prod_n};
    else    o = '{busy_s, done_s, asel_s, bsel_s, shift_s, upd_s, clr_s, prod_s};
    return o;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input bit ns, input logic v);
    if (ns) start_n = v;
    else    start_s = v;
  endtask

  // One multiply. chained: the start cycle was the previous done cycle.
  // keep_start: leave start high throughout (must be ignored while busy).
  task automatic run_mult(input logic [31:0] ta, input logic [31:0] tb_op,
                          input bit ns, input bit chained, input bit keep_start,
                          input string tag);
    bit   za, zb;
    int   n;
    logic exp_as[4], exp_bs[4];
    logic [1:0] exp_sh[4];
    obs_t o;
    logic [63:0] golden;

    // Schedule from the operands: product (i,j) is needed unless its
    // high half is known to be zero.
    za = !ns && (ta[31:16] == 16'h0);
    zb = !ns && (tb_op[31:16] == 16'h0);
    n = 0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        if ((i == 0 || !za) && (j == 0 || !zb)) begin
          exp_as[n] = 1'(i);
          exp_bs[n] = 1'(j);
          exp_sh[n] = 2'(i + j);
          n++;
        end
    golden = 64'(ta) * 64'(tb_op);

    if (!chained) begin
      @(negedge clk);
      a = ta;
      b = tb_op;
      set_start(ns, 1'b1);
      #1;
      o = grab(ns);
      check({tag, " start clr"}, 64'(o.clr), 64'h1);
      check({tag, " start busy"}, 64'(o.busy), 64'h0);
    end
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      set_start(ns, keep_start ? 1'b1 : 1'b0);
      #1;
      o = grab(ns);
      check($sformatf("%s step%0d sel", tag, k),
            {58'h0, o.busy, o.upd, o.asel, o.bsel, o.shift},
            {58'h0, 1'b1, 1'b1, exp_as[k], exp_bs[k], exp_sh[k]});
      check($sformatf("%s step%0d done/clr", tag, k), {62'h0, o.done, o.clr}, 64'h0);
    end
    @(negedge clk);
    #1;
    o = grab(ns);
    check({tag, " done"}, {62'h0, o.done, o.busy}, 64'h2);
    check({tag, " product"}, o.prod, golden);
    check({tag, " done-cycle clr"}, 64'(o.clr), keep_start ? 64'h1 : 64'h0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    obs_t o;
    logic [31:0] ra, rb;
    int mode;
    bit ns;
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    start_s = 1'b0;
    start_n = 1'b0;
    a = 32'h0;
    b = 32'h0;

    repeat (2) @(negedge clk);
    #1;
    o = grab(0);
    check("reset held s", {56'h0, o.busy, o.done, o.asel, o.bsel, o.shift, o.upd, o.clr}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    o = grab(0);
    check("after reset s", {56'h0, o.busy, o.done, o.asel, o.bsel, o.shift, o.upd, o.clr}, 64'h0);
    o = grab(1);
    check("after reset n", {56'h0, o.busy, o.done, o.asel, o.bsel, o.shift, o.upd, o.clr}, 64'h0);

    // Full four-step multiply, one-step, two-step.
    run_mult(32'h12345678, 32'h9ABCDEF0, 0, 0, 0, "case1");
    run_mult(32'h0000FFFF, 32'h0000FFFF, 0, 0, 0, "case2");
    check("case2 value", prod_s, 64'h00000000FFFE0001);
    run_mult(32'h00000002, 32'h00030000, 0, 0, 0, "case3");
    check("case3 value", prod_s, 64'h0000000000060000);

    // start held high: ignored while busy, restarts in the done cycle.
    run_mult(32'h12345678, 32'h9ABCDEF0, 0, 0, 1, "hold1");
    run_mult(32'h12345678, 32'h9ABCDEF0, 0, 1, 0, "hold2");

    // Reset while in A1B0.
    @(negedge clk);
    a = 32'h12345678;
    b = 32'h9ABCDEF0;
    start_s = 1'b1;
    repeat (3) begin
      @(negedge clk);
      start_s = 1'b0;
    end
    #1;
    check("abort in A1B0", 64'(dbg_s), 64'h3);
    reset = 1'b1;
    #1;
    o = grab(0);
    check("abort reset held", {56'h0, o.busy, o.done, o.asel, o.bsel, o.shift, o.upd, o.clr}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    o = grab(0);
    check("abort idle state", 64'(dbg_s), 64'h0);
    check("abort outputs", {56'h0, o.busy, o.done, o.asel, o.bsel, o.shift, o.upd, o.clr}, 64'h0);
    repeat (3) begin
      @(negedge clk);
      #1;
      check("abort no done", 64'(done_s), 64'h0);
    end
    run_mult(32'h0000FFFF, 32'h0000FFFF, 0, 0, 0, "post-abort");

    // Non-skipping controller always runs four steps.
    run_mult(32'h00000003, 32'h00000005, 1, 0, 0, "noskip");
    check("noskip value", prod_n, 64'd15);

    // Random operands with MSWs randomly zeroed, on either controller.
    for (int it = 0; it < 24; it++) begin
      ra = $urandom;
      rb = $urandom;
      mode = $urandom_range(0, 3);
      ns = 1'($urandom_range(0, 1));
      if (mode[0]) ra[31:16] = 16'h0;
      if (mode[1]) rb[31:16] = 16'h0;
      run_mult(ra, rb, ns, 0, 0, $sformatf("rand%0d", it));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
